// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks the shared output to one input until that packet's tail transfers.
// Optional stall timeout release is built when RR_LOCK_TIMEOUT_EN is defined.
module rr_lock_arbiter #(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic [N_REQ-1:0]           req_i,
   input  logic [N_REQ-1:0]           tail_i,
   input  logic                       out_ready_i,
   output logic                       out_valid_o,
   output logic [N_REQ-1:0]           grant_o,
   output logic [$clog2(N_REQ)-1:0]   grant_idx_o,
   output logic                       locked_o,
   output logic                       timeout_o
);

   // state  | meaning
   // IDLE   | no grant; arbitrate among req_i, winner granted at next edge
   // LOCKED | grant held until tail transfer (or stall timeout)

   localparam int IW = $clog2(N_REQ);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t           state, state_nxt;
   logic [N_REQ-1:0] grant, grant_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [IW-1:0]    ptr, ptr_nxt;
   logic             win_found;
   logic [IW-1:0]    win_idx;
   logic             xfer;
   logic             tail_hit;
   logic             tmo;

   assign out_valid_o = |(grant & req_i);
   assign xfer        = out_valid_o & out_ready_i;
   assign tail_hit    = xfer & tail_i[idx];
   assign grant_o     = grant;
   assign grant_idx_o = idx;
   assign locked_o    = (state == LOCKED);
   assign timeout_o   = tmo;

   // Lowest set request overall, overridden by the lowest one strictly above ptr.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i]) begin
            win_found = 1'b1;
            win_idx   = IW'(i);
         end
      end
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (req_i[i] && (i > int'(ptr)))
            win_idx = IW'(i);
      end
   end

`ifdef RR_LOCK_TIMEOUT_EN
   logic [15:0] stall_cnt;

   assign tmo = (state == LOCKED) && (stall_cnt == 16'(TIMEOUT_CYCLES));

   // Held at zero outside LOCKED, so entry to LOCKED always starts from zero.
   always_ff @(posedge clk or posedge arst) begin
      if (arst)
         stall_cnt <= '0;
      else if ((state == IDLE) || xfer || tmo)
         stall_cnt <= '0;
      else
         stall_cnt <= stall_cnt + 16'd1;
   end
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_nxt = state;
      grant_nxt = grant;
      idx_nxt   = idx;
      ptr_nxt   = ptr;
      case (state)
         IDLE: begin
            if (win_found) begin
               grant_nxt = N_REQ'(1) << win_idx;
               idx_nxt   = win_idx;
               state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (tail_hit || tmo) begin
               grant_nxt = '0;
               idx_nxt   = '0;
               ptr_nxt   = idx;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state <= IDLE;
         grant <= '0;
         idx   <= '0;
         ptr   <= IW'(N_REQ - 1);
      end else begin
         state <= state_nxt;
         grant <= grant_nxt;
         idx   <= idx_nxt;
         ptr   <= ptr_nxt;
      end
   end

endmodule

// File: tb/tb_rr_lock_arbiter.sv
// Self-checking bench for rr_lock_arbiter: vector table, corner sequences, randomized run vs. reference model.
module tb_rr_lock_arbiter;
   localparam int N   = 4;
   localparam int TMO = 8;

   logic       clk = 1'b0;
   logic       arst;
   logic [3:0] req, tail;
   logic       ready;
   logic       out_valid;
   logic [3:0] grant;
   logic [1:0] gidx;
   logic       locked, timeout;

   always #5 clk = ~clk;

   rr_lock_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .arst(arst), .req_i(req), .tail_i(tail), .out_ready_i(ready),
      .out_valid_o(out_valid), .grant_o(grant), .grant_idx_o(gidx),
      .locked_o(locked), .timeout_o(timeout)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] tail;
      logic       ready;
      logic [3:0] grant;
      logic       locked;
      logic       valid;
   } vec_t;

   vec_t tbl[24];
   int   checks = 0;
   int   failures = 0;

   // Reference model: owner of the lock (-1 = none), last released owner, stalled cycles.
   int m_owner, m_last, m_stall;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int idx_of(input logic [3:0] g);
      for (int i = 0; i < N; i++) if (g[i]) return i;
      return 0;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b1; req = '0; tail = '0; ready = 1'b0;
      #1;
      chk("rst_grant", int'(grant), 0);
      chk("rst_idx", int'(gidx), 0);
      chk("rst_locked", int'(locked), 0);
      chk("rst_timeout", int'(timeout), 0);
      step();
      arst = 1'b0;
   endtask

   function automatic int m_tmo();
`ifdef RR_LOCK_TIMEOUT_EN
      return (m_owner >= 0 && m_stall == TMO) ? 1 : 0;
`else
      return 0;
`endif
   endfunction

   task automatic model_step();
      bit hit, xf;
      hit = (m_tmo() != 0);
      if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_last + k) % N;
            if (req[c]) begin
               m_owner = c;
               m_stall = 0;
               break;
            end
         end
      end else begin
         xf = req[m_owner] && ready;
         if (hit || (xf && tail[m_owner])) begin
            m_last  = m_owner;
            m_owner = -1;
            m_stall = 0;
         end else if (xf)
            m_stall = 0;
         else
            m_stall++;
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{4'b1010, 4'b1010, 1'b1, 4'b0010, 1'b1, 1'b0};
      tbl[1]  = '{4'b1010, 4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[2]  = '{4'b1010, 4'b1010, 1'b1, 4'b1000, 1'b1, 1'b0};
      tbl[3]  = '{4'b1010, 4'b1010, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
      tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[6]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0};
      tbl[7]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[8]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0};
      tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[10] = '{4'b1111, 4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0};
      tbl[11] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[12] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0};
      tbl[13] = '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[14] = '{4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};
      tbl[15] = '{4'b0000, 4'b0000, 1'b1, 4'b0100, 1'b1, 1'b0};
      tbl[16] = '{4'b1011, 4'b1011, 1'b1, 4'b0100, 1'b1, 1'b0};
      tbl[17] = '{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1};
      tbl[18] = '{4'b0100, 4'b0100, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[19] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0};
      tbl[20] = '{4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, 1'b0};
      tbl[21] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1};
      tbl[22] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0};
      tbl[23] = '{4'b0001, 4'b0001, 1'b1, 4'b0000, 1'b0, 1'b1};

      do_reset();

      for (int i = 0; i < 24; i++) begin
         req = tbl[i].req; tail = tbl[i].tail; ready = tbl[i].ready;
         #1;
         chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].valid));
         step();
         chk($sformatf("tbl%0d_grant", i), int'(grant), int'(tbl[i].grant));
         chk($sformatf("tbl%0d_idx", i), int'(gidx), idx_of(tbl[i].grant));
         chk($sformatf("tbl%0d_locked", i), int'(locked), int'(tbl[i].locked));
      end

      // Stalled 3-flit packet on input 2 while input 0 starts requesting.
      req = 4'b0100; tail = 4'b0000; ready = 1'b1;
      step();
      chk("stall_grant_head", int'(grant), 4'b0100);
      step();
      chk("stall_grant_f1", int'(grant), 4'b0100);
      req = 4'b0101; ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk($sformatf("stall_hold%0d", k), int'(grant), 4'b0100);
      end
      ready = 1'b1;
      step();
      chk("stall_grant_f2", int'(grant), 4'b0100);
      tail = 4'b0100;
      #1;
      chk("stall_tail_valid", int'(out_valid), 1);
      step();
      chk("stall_bubble", int'(grant), 4'b0000);
      chk("stall_bubble_locked", int'(locked), 0);
      tail = 4'b0000;
      step();
      chk("stall_next_grant", int'(grant), 4'b0001);

      // Asynchronous reset in the middle of a packet on input 1.
      do_reset();
      req = 4'b0010; tail = 4'b0000; ready = 1'b0;
      step();
      chk("arst_pre_grant", int'(grant), 4'b0010);
      #2;
      arst = 1'b1;
      #1;
      chk("arst_grant", int'(grant), 0);
      chk("arst_locked", int'(locked), 0);
      chk("arst_idx", int'(gidx), 0);
      step();
      arst = 1'b0; req = 4'b0011;
      step();
      chk("arst_resume_grant", int'(grant), 4'b0001);

      // Input 3 locked with downstream permanently stalled.
      do_reset();
      req = 4'b1000; tail = 4'b0000; ready = 1'b0;
      step();
      chk("tmo_grant", int'(grant), 4'b1000);
`ifdef RR_LOCK_TIMEOUT_EN
      for (int k = 1; k <= TMO + 1; k++) begin
         chk($sformatf("tmo_pulse_c%0d", k), int'(timeout), (k == TMO + 1) ? 1 : 0);
         if (k <= TMO) begin
            step();
            chk($sformatf("tmo_held_c%0d", k), int'(grant), 4'b1000);
         end
      end
      step();
      chk("tmo_release_grant", int'(grant), 0);
      chk("tmo_release_locked", int'(locked), 0);
      chk("tmo_after_pulse", int'(timeout), 0);
      req = 4'b1100;
      step();
      chk("tmo_ptr_grant", int'(grant), 4'b0100);
`else
      for (int k = 0; k < 20; k++) begin
         step();
         chk($sformatf("nolimit_grant%0d", k), int'(grant), 4'b1000);
         chk($sformatf("nolimit_tmo%0d", k), int'(timeout), 0);
      end
      chk("nolimit_locked", int'(locked), 1);
`endif

      // Randomized traffic against the reference model.
      do_reset();
      m_owner = -1; m_last = N - 1; m_stall = 0;
      for (int c = 0; c < 1500; c++) begin
         req   = 4'($urandom);
         tail  = 4'($urandom) & 4'($urandom);
         ready = ($urandom_range(3) != 0);
         if (c % 300 < 40) ready = 1'b0;
         #1;
         chk("rnd_valid", int'(out_valid), (m_owner >= 0 && req[m_owner]) ? 1 : 0);
         chk("rnd_timeout", int'(timeout), m_tmo());
         model_step();
         step();
         chk("rnd_grant", int'(grant), (m_owner >= 0) ? (1 << m_owner) : 0);
         chk("rnd_idx", int'(gidx), (m_owner >= 0) ? m_owner : 0);
         chk("rnd_locked", int'(locked), (m_owner >= 0) ? 1 : 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/rr_lock_arbiter.md
RR_LOCK_ARBITER -- requirements
Module: rr_lock_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesting input ports (2..16).
REQ-002 Parameter TIMEOUT_CYCLES, default 255, stall limit in cycles while locked (1..65535); used only when RR_LOCK_TIMEOUT_EN is defined.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port arst, input, 1: reset, asynchronous, active-high.
REQ-005 Port req_i, input, N_REQ: per-input flit valid; the flit is a head flit when that input is not granted.
REQ-006 Port tail_i, input, N_REQ: per-input flag marking the current flit as the packet tail.
REQ-007 Port out_ready_i, input, 1: downstream ready for the shared output port.
REQ-008 Port out_valid_o, output, 1: equals OR of (grant_o AND req_i).
REQ-009 Port grant_o, output, N_REQ: one-hot registered grant, or all zero.
REQ-010 Port grant_idx_o, output, clog2(N_REQ): binary index of the granted input; 0 when none is granted.
REQ-011 Port locked_o, output, 1: high in state LOCKED.
REQ-012 Port timeout_o, output, 1: one-cycle pulse on a forced release.

Function
REQ-013 Two states SHALL exist: IDLE and LOCKED.
REQ-014 In IDLE with any req_i set, the winner SHALL be taken from the masked requests (indices strictly above ptr, cyclically), lowest index first; if no masked request is set, the lowest set index of req_i SHALL win.
REQ-015 The winner SHALL appear on grant_o and grant_idx_o at the next rising edge, with the state moving to LOCKED; latency from req to grant is 1 cycle.
REQ-016 In IDLE with req_i all zero, the state SHALL hold and grant_o SHALL stay zero.
REQ-017 In LOCKED, grant_o SHALL hold regardless of other req_i bits.
REQ-018 A transfer SHALL be defined as out_valid_o AND out_ready_i.
REQ-019 A transfer with tail_i[grant_idx_o] set SHALL, at that edge, clear grant_o, load ptr with grant_idx_o and return the state to IDLE.
REQ-020 After a tail transfer there SHALL be exactly one IDLE bubble cycle before the next grant.
REQ-021 A single-flit packet (head and tail on the same flit) SHALL hold LOCKED for as many cycles as that one transfer takes.
REQ-022 If the granted input deasserts req_i while LOCKED, the arbiter SHALL remain LOCKED with out_valid_o at 0.
REQ-023 tail_i bits of non-granted inputs SHALL be ignored.
REQ-024 With one persistent requester, that requester SHALL be regranted after every bubble.
REQ-025 With all requesters persistent, grants SHALL rotate 0,1,...,N_REQ-1,0 with no starvation.

Reset
REQ-026 While arst is high, and immediately on its assertion, the following SHALL hold: grant_o is 0, grant_idx_o is 0, locked_o is 0, timeout_o is 0, state is IDLE, ptr is N_REQ-1 (index 0 has highest priority), and the timeout counter is 0.
REQ-027 Reset asserted mid-packet SHALL abandon the lock with no tail required.
REQ-028 Arbitration SHALL resume at the first rising edge after arst deasserts.

Configuration
REQ-029 Macro RR_LOCK_TIMEOUT_EN defined: a counter SHALL operate in LOCKED.
- The counter clears on every transfer and on entry to LOCKED, and increments each LOCKED cycle without a transfer.
- When it reaches TIMEOUT_CYCLES, the next edge forces release exactly as a tail transfer (ptr is loaded with grant_idx_o).
- timeout_o pulses for that one cycle.
REQ-030 Macro RR_LOCK_TIMEOUT_EN undefined: no counter SHALL be built, timeout_o SHALL be tied 0, and the lock SHALL be released only by a tail transfer or reset.

Verification
REQ-031 After reset, req_i=4'b1010 with out_ready_i=1 and a single-flit packet: grant_o=4'b0010 one cycle after req, then after the tail and bubble grant_o=4'b1000.
REQ-032 req_i=4'b1111 held, every flit a tail, out_ready_i=1: grant_idx_o sequence 0,1,2,3,0, each grant separated by one bubble.
REQ-033 Input 2 granted, 3-flit packet, out_ready_i low for 5 cycles mid-packet, req_i[0] raised meanwhile: grant_o stays 4'b0100 until the tail transfer, then one bubble, then grant_o=4'b1000 if req_i[3] is set, else 4'b0001.
REQ-034 arst pulsed while input 1 is locked: grant_o=0 and locked_o=0 immediately; with req_i=4'b0011 after release, grant_o=4'b0001.
REQ-035 RR_LOCK_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, input 3 granted, out_ready_i=0 held: timeout_o pulses on the 9th locked cycle, grant_o then clears and ptr=3; RR_LOCK_TIMEOUT_EN undefined: the lock holds indefinitely and timeout_o stays 0.
